// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, port ids and the width helper for the arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Smallest width able to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) result = k + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt: loadable down-counter tracking the memory read latency.
// Latency: load takes effect on the next edge; o_done is combinational from the count.
// Backpressure: none; i_dec simply holds the count when low, and the count saturates at 0.
module mem_arb_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the fetch or data port onto one fixed-latency single-ported memory.
// Latency: request sampled at edge k -> mem_en in cycle k+1 -> ack in cycle k+2+MEM_LAT.
// Backpressure: requesters hold req until ack; hlt blocks fetch grants. MEM_ARB_RR_EN = round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = clog2(MEM_LAT + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_port;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  logic w_i_elig;
  logic w_d_elig;
  logic w_pick_d;
  logic w_grant;
  logic w_dec;
  logic w_done;
  logic w_capture;

  assign w_i_elig = i_req && !hlt;
  assign w_d_elig = d_req;
  assign w_grant  = (r_state == IDLE) && (w_i_elig || w_d_elig);

  // The command cycle (mem_en high) is not a latency cycle, so counting starts after it.
  assign w_dec     = (r_state == WAIT) && !r_mem_en;
  assign w_capture = w_dec && w_done;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Remember the last granted port so a tie goes to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_I;
    end else if (w_grant) begin
      r_last_grant <= w_pick_d ? PORT_D : PORT_I;
    end
  end

  assign w_pick_d = w_d_elig && (!w_i_elig || (r_last_grant == PORT_I));
`else
  // Data access belongs to the older instruction, so it always wins a tie.
  assign w_pick_d = w_d_elig;
`endif

  mem_arb_lat_cnt #(
    .W (CW)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_grant),
    .i_load_val (CW'(MEM_LAT)),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: IDLE grants, WAIT counts out the latency, RESP lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = WAIT;
      WAIT:    if (w_capture) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: one-cycle ack to the granted port while in RESP.
  always_comb begin
    i_ack = 1'b0;
    d_ack = 1'b0;
    busy  = (r_state != IDLE);
    if (r_state == RESP) begin
      i_ack = (r_port == PORT_I);
      d_ack = (r_port == PORT_D);
    end
  end

  // Command latch on grant and read-data capture at the end of the latency window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port      <= PORT_I;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_en <= w_grant;
      if (w_grant) begin
        r_port      <= w_pick_d ? PORT_D : PORT_I;
        r_mem_we    <= w_pick_d && d_we;
        r_mem_addr  <= w_pick_d ? d_addr : i_addr;
        r_mem_wdata <= w_pick_d ? d_wdata : '0;
      end
      if (w_capture) begin
        if (r_port == PORT_I) begin
          r_i_rdata <= mem_rdata;
        end else if (!r_mem_we) begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic [15:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n;
  logic hlt;

  logic        a_i_req, a_d_req, a_d_we, a_i_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;
  logic [15:0] a_i_addr, a_d_addr, a_d_wdata, a_i_rdata, a_d_rdata;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_i_req, b_d_req, b_d_we, b_i_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ack_a  = 0;

  cmd_t qc_a[$];
  cmd_t qc_b[$];
  ack_t qa_a[$];
  ack_t qa_b[$];

  logic [15:0] pipe_a [4];
  logic [15:0] pipe_b;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr  = 16'h0000;
  logic [15:0] wr_data  = 16'h0000;

  mem_arbiter #(.MEM_LAT(4), .AW(16), .DW(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: fixed table plus the most recent store.
  function automatic logic [15:0] rd(input logic [15:0] a);
    if (wr_valid && (a == wr_addr)) return wr_data;
    case (a)
      16'h0010: return 16'hB123;
      16'h0020: return 16'h5A5A;
      16'h0030: return 16'h0C0C;
      16'h8000: return 16'h1234;
      default:  return 16'h0000;
    endcase
  endfunction

  // Fixed-latency memories; DEAD marks cycles where no read data is valid.
  always @(posedge clk) begin
    pipe_a[0] <= (a_mem_en && !a_mem_we) ? rd(a_mem_addr) : 16'hDEAD;
    for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= (b_mem_en && !b_mem_we) ? rd(b_mem_addr) : 16'hDEAD;
    if (a_mem_en && a_mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= a_mem_addr;
      wr_data  <= a_mem_wdata;
    end
  end

  assign a_mem_rdata = pipe_a[3];
  assign b_mem_rdata = pipe_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void exp_cmd_a(input int c, input logic [15:0] a, input logic we, input logic [15:0] wd);
    cmd_t e;
    e.cyc = c; e.addr = a; e.we = we; e.wdata = wd;
    qc_a.push_back(e);
  endfunction

  function automatic void exp_ack_a(input int c, input logic p, input logic [15:0] rdv);
    ack_t e;
    e.cyc = c; e.port = p; e.rdata = rdv;
    qa_a.push_back(e);
  endfunction

  function automatic void exp_cmd_b(input int c, input logic [15:0] a);
    cmd_t e;
    e.cyc = c; e.addr = a; e.we = 1'b0; e.wdata = 16'h0000;
    qc_b.push_back(e);
  endfunction

  function automatic void exp_ack_b(input int c, input logic [15:0] rdv);
    ack_t e;
    e.cyc = c; e.port = 1'b0; e.rdata = rdv;
    qa_b.push_back(e);
  endfunction

  // Monitor for the MEM_LAT=4 instance.
  always @(negedge clk) begin
    cmd_t ec;
    ack_t ea;
    check("a_ack_exclusive", 32'(a_i_ack & a_d_ack), 32'd0);
    if (a_mem_en) begin
      check("a_cmd_pending", 32'(qc_a.size() != 0), 32'd1);
      if (qc_a.size() != 0) begin
        ec = qc_a.pop_front();
        check("a_cmd_cycle", cyc, ec.cyc);
        check("a_cmd_addr", 32'(a_mem_addr), 32'(ec.addr));
        check("a_cmd_we", 32'(a_mem_we), 32'(ec.we));
        if (ec.we) check("a_cmd_wdata", 32'(a_mem_wdata), 32'(ec.wdata));
      end
    end
    if (a_i_ack || a_d_ack) begin
      n_ack_a++;
      check("a_ack_pending", 32'(qa_a.size() != 0), 32'd1);
      if (qa_a.size() != 0) begin
        ea = qa_a.pop_front();
        check("a_ack_cycle", cyc, ea.cyc);
        check("a_ack_port", 32'(a_d_ack), 32'(ea.port));
        check("a_ack_rdata", 32'(ea.port ? a_d_rdata : a_i_rdata), 32'(ea.rdata));
      end
    end
  end

  // Monitor for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    cmd_t ec;
    ack_t ea;
    if (b_mem_en) begin
      check("b_cmd_pending", 32'(qc_b.size() != 0), 32'd1);
      if (qc_b.size() != 0) begin
        ec = qc_b.pop_front();
        check("b_cmd_cycle", cyc, ec.cyc);
        check("b_cmd_addr", 32'(b_mem_addr), 32'(ec.addr));
      end
    end
    if (b_i_ack || b_d_ack) begin
      check("b_ack_pending", 32'(qa_b.size() != 0), 32'd1);
      if (qa_b.size() != 0) begin
        ea = qa_b.pop_front();
        check("b_ack_cycle", cyc, ea.cyc);
        check("b_ack_is_fetch", 32'(b_i_ack), 32'd1);
        check("b_ack_rdata", 32'(b_i_rdata), 32'(ea.rdata));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for an ack on instance A; returns at the negedge of the ack cycle.
  task automatic wait_ack_a(input logic port);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (port ? a_d_ack : a_i_ack) ok = 1'b1;
    end
    check(port ? "a_d_ack_seen" : "a_i_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_ack_b();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (b_i_ack) ok = 1'b1;
    end
    check("b_i_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic fetch_a(input logic [15:0] addr);
    a_i_req  = 1'b1;
    a_i_addr = addr;
    wait_ack_a(1'b0);
    a_i_req  = 1'b0;
  endtask

  task automatic data_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    a_d_req   = 1'b1;
    a_d_we    = we;
    a_d_addr  = addr;
    a_d_wdata = wdata;
    wait_ack_a(1'b1);
    a_d_req   = 1'b0;
    a_d_we    = 1'b0;
  endtask

  function automatic logic any_out_a();
    return |{a_i_rdata, a_i_ack, a_d_rdata, a_d_ack, a_mem_en, a_mem_we,
             a_mem_addr, a_mem_wdata, a_busy};
  endfunction

  function automatic logic any_out_b();
    return |{b_i_rdata, b_i_ack, b_d_rdata, b_d_ack, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_busy};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ack0;
    int en_cnt;
    int busy_cnt;

    rst_n = 1'b1; hlt = 1'b0;
    a_i_req = 1'b0; a_i_addr = 16'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = 16'h0; a_d_wdata = 16'h0;
    b_i_req = 1'b0; b_i_addr = 16'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 16'h0; b_d_wdata = 16'h0;
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_outputs_a", 32'(any_out_a()), 32'd0);
    check("rst_outputs_b", 32'(any_out_b()), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of WAIT aborts the fetch with no ack.
    base = cyc;
    exp_cmd_a(base + 1, 16'h0010, 1'b0, 16'h0);
    a_i_req = 1'b1; a_i_addr = 16'h0010;
    idle(3);
    check("abort_busy_before", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs_zero", 32'(any_out_a()), 32'd0);
    a_i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack0 = n_ack_a;
    idle(12);
    check("abort_no_ack", n_ack_a - ack0, 0);

    // Single fetch.
    base = cyc;
    exp_cmd_a(base + 1, 16'h0010, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b0, 16'hB123);
    fetch_a(16'h0010);
    idle(3);

    // Collision with last grant = fetch: data first in both modes.
    base = cyc;
    exp_cmd_a(base + 1, 16'h8000, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b1, 16'h1234);
    exp_cmd_a(base + 8, 16'h0020, 1'b0, 16'h0);
    exp_ack_a(base + 13, 1'b0, 16'h5A5A);
    fork
      fetch_a(16'h0020);
      data_a(1'b0, 16'h8000, 16'h0);
    join
    idle(3);

    // Store: d_rdata keeps the previous load value.
    base = cyc;
    exp_cmd_a(base + 1, 16'h0042, 1'b1, 16'hBEEF);
    exp_ack_a(base + 6, 1'b1, 16'h1234);
    data_a(1'b1, 16'h0042, 16'hBEEF);
    idle(3);

    // Collision with last grant = data; the load reads back the stored word.
    base = cyc;
`ifdef MEM_ARB_RR_EN
    exp_cmd_a(base + 1, 16'h0010, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b0, 16'hB123);
    exp_cmd_a(base + 8, 16'h0042, 1'b0, 16'h0);
    exp_ack_a(base + 13, 1'b1, 16'hBEEF);
`else
    exp_cmd_a(base + 1, 16'h0042, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b1, 16'hBEEF);
    exp_cmd_a(base + 8, 16'h0010, 1'b0, 16'h0);
    exp_ack_a(base + 13, 1'b0, 16'hB123);
`endif
    fork
      fetch_a(16'h0010);
      data_a(1'b0, 16'h0042, 16'h0);
    join
    idle(3);

    // Halt blocks fetch grants but not data grants.
    hlt = 1'b1; a_i_req = 1'b1; a_i_addr = 16'h0030;
    en_cnt = 0; busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      en_cnt   += 32'(a_mem_en);
      busy_cnt += 32'(a_busy);
    end
    check("halt_no_mem_en", en_cnt, 0);
    check("halt_not_busy", busy_cnt, 0);
    base = cyc;
    exp_cmd_a(base + 1, 16'h8000, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b1, 16'h1234);
    data_a(1'b0, 16'h8000, 16'h0);
    idle(3);
    check("halt_still_idle", 32'(a_busy), 32'd0);
    check("i_rdata_held", 32'(a_i_rdata), 32'h0000B123);
    a_i_req = 1'b0; hlt = 1'b0;
    idle(2);

    // Halt rising during an in-flight fetch does not cancel it.
    base = cyc;
    exp_cmd_a(base + 1, 16'h0030, 1'b0, 16'h0);
    exp_ack_a(base + 6, 1'b0, 16'h0C0C);
    fork
      fetch_a(16'h0030);
      begin idle(3); hlt = 1'b1; end
    join
    hlt = 1'b0;
    idle(3);

    // MEM_LAT = 1: held fetch served back-to-back, new address after the first ack.
    base = cyc;
    exp_cmd_b(base + 1, 16'h0010);
    exp_ack_b(base + 3, 16'hB123);
    exp_cmd_b(base + 5, 16'h0020);
    exp_ack_b(base + 7, 16'h5A5A);
    b_i_req = 1'b1; b_i_addr = 16'h0010;
    wait_ack_b();
    b_i_addr = 16'h0020;
    wait_ack_b();
    b_i_req = 1'b0;
    idle(6);

    check("a_cmd_queue_empty", qc_a.size(), 0);
    check("a_ack_queue_empty", qa_a.size(), 0);
    check("b_cmd_queue_empty", qc_b.size(), 0);
    check("b_ack_queue_empty", qa_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
